// File: rtl/sar_avg_seq.sv
// sar_avg_seq
// Conversion sequencer on the initiator side of the SAR start/eoc/result
// handshake. It issues a start on a programmable sample period and captures
// each finished result. It averages 2^LogN results and presents the floor
// average on a valid/ready port. Sample ticks that cannot be served are
// flagged on a sticky overrun bit.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   en_i       : sequencer enable
//   period_i   : sample period minus one, in clk_i cycles
//   clr_ovr_i  : clears overrun_o (a simultaneous set wins)
//   eoc_i      : converter idle / end-of-conversion level
//   result_i   : converter result, valid while eoc_i high after a conversion
//   start_o    : one-cycle conversion request
//   avg_o      : averaged result
//   valid_o    : avg_o valid
//   ready_i    : consumer accepts avg_o
//   overrun_o  : sticky, a sample tick was dropped
//   busy_o     : high in any state except IDLE
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | disabled, period counter frozen
// WAIT_TICK | waiting for a sample tick with the converter idle
// START     | start_o asserted for this single cycle
// WAIT_ACK  | waiting for the converter to drop eoc_i
// WAIT_EOC  | conversion in flight, waiting for eoc_i to rise
// OUTPUT    | average word presented, waiting for ready_i

module sar_avg_seq #(
    parameter int Width    = 8,
    parameter int LogN     = 2,
    parameter int PerWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic [PerWidth-1:0] period_i,
    input  logic                clr_ovr_i,
    input  logic                eoc_i,
    input  logic [Width-1:0]    result_i,
    output logic                start_o,
    output logic [Width-1:0]    avg_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    output logic                busy_o
);

    localparam int AccW = Width + LogN;
    localparam int CntW = (LogN > 0) ? LogN : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((1 << LogN) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_START,
        S_WAIT_ACK,
        S_WAIT_EOC,
        S_OUTPUT
    } state_t;

    state_t              r_state;
    logic [PerWidth-1:0] r_per;
    logic [AccW-1:0]     r_acc;
    logic [CntW-1:0]     r_cnt;
    logic                r_start;
    logic [Width-1:0]    r_avg;
    logic                r_valid;
    logic                r_ovr;
    logic                r_busy;

    logic                w_tick;
    logic                w_drop;
    logic [AccW-1:0]     w_sum;
    logic [AccW-1:0]     w_shift;
    logic [Width-1:0]    w_avg;

    // The counter only runs outside IDLE, so a stale zero in IDLE never ticks.
    assign w_tick  = (r_state != S_IDLE) && (r_per == '0);
    // A tick is served only in WAIT_TICK with the converter idle.
    assign w_drop  = w_tick && !((r_state == S_WAIT_TICK) && eoc_i);
    // Accumulator is wide enough for 2^LogN full-scale results.
    assign w_sum   = r_acc + AccW'(result_i);
    assign w_shift = w_sum >> LogN;
    assign w_avg   = w_shift[Width-1:0];

    assign start_o   = r_start;
    assign avg_o     = r_avg;
    assign valid_o   = r_valid;
    assign overrun_o = r_ovr;
    assign busy_o    = r_busy;

    // Period counter: loaded when leaving IDLE, reloads at terminal count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_per <= '0;
        end else if (r_state == S_IDLE) begin
            if (en_i) begin
                r_per <= period_i;
            end
        end else if (r_per == '0) begin
            r_per <= period_i;
        end else begin
            r_per <= r_per - PerWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr_i) begin
            r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_start <= 1'b0;
            r_avg   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_start <= 1'b0;
                    if (en_i) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_TICK;
                    end
                end
                S_WAIT_TICK: begin
                    if (!en_i) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_tick && eoc_i) begin
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_start <= 1'b0;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!eoc_i) begin
                        r_state <= S_WAIT_EOC;
                    end
                end
                S_WAIT_EOC: begin
                    if (eoc_i) begin
                        if (!en_i) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_cnt == CntLast) begin
                            r_avg   <= w_avg;
                            r_valid <= 1'b1;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= S_OUTPUT;
                        end else begin
                            r_acc   <= w_sum;
                            r_cnt   <= r_cnt + CntW'(1);
                            r_state <= S_WAIT_TICK;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        if (en_i) begin
                            r_state <= S_WAIT_TICK;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
